// File: rtl/countdown_timer_pkg.sv
// Shared types for the maze-game countdown timer: FSM states, the BCD time
// word and the saturation limit of 59:59.9 expressed in tenths.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int unsigned MAX_TENTHS = 35999;

    typedef struct packed {
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
        logic [3:0] tenth;
    } bcd_time_t;

    function automatic logic is_zero(input bcd_time_t t);
        return (t == '0);
    endfunction

    // True below 00:10.0: only seconds units and tenths are nonzero.
    function automatic logic under_10s(input bcd_time_t t);
        return (t.min1 == 4'd0) && (t.min0 == 4'd0) && (t.sec1 == 4'd0);
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_time_adder.sv
// Combinational BCD time arithmetic: optional bonus add and optional one-tenth
// decrement in one step, saturated at 59:59.9 and floored at 00:00.0.
module bcd_time_adder
    import countdown_timer_pkg::*;
#(
    parameter int unsigned BONUS_SEC = 5
) (
    input  bcd_time_t i_value,
    input  logic      i_bonus_en,
    input  logic      i_dec_en,
    output bcd_time_t o_value
);

    localparam logic [16:0] BONUS_TENTHS = 17'(BONUS_SEC * 10);
    localparam logic [16:0] SAT_TENTHS   = 17'(MAX_TENTHS);

    logic [16:0] w_tenths;
    logic [16:0] w_sum;
    logic [16:0] w_mins;
    logic [16:0] w_rem;

    // Work in binary tenths so bonus and borrow share one carry chain,
    // then split back into minutes/seconds/tenths digits.
    always_comb begin
        w_tenths = 17'(i_value.min1) * 17'd6000 + 17'(i_value.min0) * 17'd600
                 + 17'(i_value.sec1) * 17'd100  + 17'(i_value.sec0) * 17'd10
                 + 17'(i_value.tenth);
        w_sum = w_tenths + (i_bonus_en ? BONUS_TENTHS : 17'd0);
        if (i_dec_en && (w_sum != 17'd0)) begin
            w_sum = w_sum - 17'd1;
        end
        if (w_sum > SAT_TENTHS) begin
            w_sum = SAT_TENTHS;
        end
        w_mins        = w_sum / 17'd600;
        w_rem         = w_sum % 17'd600;
        o_value.min1  = 4'(w_mins / 17'd10);
        o_value.min0  = 4'(w_mins % 17'd10);
        o_value.sec1  = 4'(w_rem / 17'd100);
        o_value.sec0  = 4'((w_rem % 17'd100) / 17'd10);
        o_value.tenth = 4'(w_rem % 17'd10);
    end

endmodule

// File: rtl/countdown_timer.sv
// Maze-game countdown: counts down from a preset in tenths of a second with
// start/pause toggle, reload and trophy time bonus.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned PRESET_MIN = 2,
    parameter int unsigned PRESET_SEC = 0,
    parameter int unsigned BONUS_SEC  = 5
) (
    input  logic       clk_10Hz,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       cnt_enable,
    input  logic       load,
    input  logic       bonus,
    output logic [3:0] tenth,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic       running,
    output logic       time_up,
    output logic       warning
);

    localparam bcd_time_t PRESET = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                    4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10), 4'd0};

    state_t    r_state;
    bcd_time_t r_value;
    logic      r_btn_d;
    logic      r_running;
    logic      r_time_up;
    logic      r_warning;

    logic      w_press;
    logic      w_bonus_en;
    logic      w_dec_en;
    bcd_time_t w_sum;

    assign w_press    = btn_start & ~r_btn_d;
    assign w_bonus_en = bonus & ~load & (r_state != ST_EXPIRED);
    // A press in RUN pauses without consuming a tenth.
    assign w_dec_en   = ~load & (r_state == ST_RUN) & ~w_press & cnt_enable;

    bcd_time_adder #(
        .BONUS_SEC (BONUS_SEC)
    ) u_adder (
        .i_value    (r_value),
        .i_bonus_en (w_bonus_en),
        .i_dec_en   (w_dec_en),
        .o_value    (w_sum)
    );

    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_value   <= PRESET;
            r_btn_d   <= 1'b0;
            r_running <= 1'b0;
            r_time_up <= 1'b0;
            r_warning <= 1'b0;
        end else begin
            r_btn_d <= btn_start;
            if (load) begin
                r_state   <= ST_IDLE;
                r_value   <= PRESET;
                r_running <= 1'b0;
                r_time_up <= 1'b0;
                r_warning <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_PAUSE: begin
                        r_value <= w_sum;
                        if (w_press && is_zero(w_sum)) begin
                            r_state   <= ST_EXPIRED;
                            r_time_up <= 1'b1;
                        end else if (w_press) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_warning <= under_10s(w_sum);
                        end
                    end
                    ST_RUN: begin
                        r_value <= w_sum;
                        if (w_press) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                            r_warning <= 1'b0;
                        end else if (is_zero(w_sum)) begin
                            r_state   <= ST_EXPIRED;
                            r_running <= 1'b0;
                            r_time_up <= 1'b1;
                            r_warning <= 1'b0;
                        end else begin
                            r_warning <= under_10s(w_sum);
                        end
                    end
                    ST_EXPIRED: begin
                        r_value <= r_value;
                    end
                endcase
            end
        end
    end

    assign {min1, min0, sec1, sec0, tenth} = r_value;
    assign running = r_running;
    assign time_up = r_time_up;
    assign warning = r_warning;

endmodule
